// File: rtl/blinky_pkg.sv
// Shared definitions for the LED blinker control path: button FSM states and default timings.
package blinky_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 1_000_000;
  localparam int unsigned LONG_CYCLES_DEF = 50_000_000;

endpackage : blinky_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/btn_toggle.sv
// Push-button conditioner: synchronise, debounce, toggle en_o on each accepted press.
// Optional long-press detection (long_o, forces en_o off) under BTN_TOGGLE_LONG_PRESS_EN.
module btn_toggle
  import blinky_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
`ifdef BTN_TOGGLE_LONG_PRESS_EN
 ,parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic en_o,
  output logic press_o
`ifdef BTN_TOGGLE_LONG_PRESS_EN
 ,output logic long_o
`endif
);

  localparam int unsigned      DB_DW   = $clog2(DB_CYCLES);
  localparam logic [DB_DW-1:0] DB_LAST = DB_DW'(DB_CYCLES - 1);

  btn_state_e       state;
  btn_state_e       state_nxt;
  logic             btn_s;
  logic [DB_DW-1:0] db_cnt;
  logic             db_done;
  logic             accept;
  logic             en_nxt;
  logic             press_nxt;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_i),
    .q_o    (btn_s)
  );

  assign db_done = (db_cnt == DB_LAST);
  assign accept  = (state == DB_PRESS) && btn_s && db_done;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (btn_s) state_nxt = DB_PRESS;
      DB_PRESS: begin
        if (!btn_s)       state_nxt = IDLE;
        else if (db_done) state_nxt = PRESSED;
      end
      PRESSED:    if (!btn_s) state_nxt = DB_RELEASE;
      DB_RELEASE: begin
        if (btn_s)        state_nxt = PRESSED;
        else if (db_done) state_nxt = IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Debounce counter restarts on every state change, so it never passes DB_LAST
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt <= '0;
    end else if (state_nxt != state) begin
      db_cnt <= '0;
    end else if ((state == DB_PRESS) || (state == DB_RELEASE)) begin
      db_cnt <= db_cnt + DB_DW'(1);
    end
  end

`ifdef BTN_TOGGLE_LONG_PRESS_EN
  localparam int unsigned      LP_DW   = $clog2(LONG_CYCLES);
  localparam logic [LP_DW-1:0] LP_LAST = LP_DW'(LONG_CYCLES - 1);
  localparam logic [LP_DW-1:0] LP_PRE  = LP_DW'(LONG_CYCLES - 2);

  logic [LP_DW-1:0] lp_cnt;
  logic             long_hit;
  logic             long_nxt;

  // Fires only on the step into LP_LAST; saturation makes it once per press
  assign long_hit = (state == PRESSED) && (lp_cnt == LP_PRE);

  // Hold-time counter: cleared on a fresh accept, held across release bounces
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lp_cnt <= '0;
    end else if (accept) begin
      lp_cnt <= '0;
    end else if ((state == PRESSED) && (lp_cnt != LP_LAST)) begin
      lp_cnt <= lp_cnt + LP_DW'(1);
    end
  end
`endif

  // Output logic (next values of the registered outputs)
  always_comb begin
    press_nxt = accept;
    en_nxt    = en_o ^ accept;
`ifdef BTN_TOGGLE_LONG_PRESS_EN
    long_nxt  = long_hit;
    if (long_hit) en_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_o    <= 1'b0;
      press_o <= 1'b0;
`ifdef BTN_TOGGLE_LONG_PRESS_EN
      long_o  <= 1'b0;
`endif
    end else begin
      en_o    <= en_nxt;
      press_o <= press_nxt;
`ifdef BTN_TOGGLE_LONG_PRESS_EN
      long_o  <= long_nxt;
`endif
    end
  end

endmodule : btn_toggle

// File: tb/tb_btn_toggle.sv
// Directed bench for btn_toggle with DB_CYCLES=4, LONG_CYCLES=16.
module tb_btn_toggle;

  logic clk;
  logic rst_ni;
  logic btn_i;
  logic en_o;
  logic press_o;
`ifdef BTN_TOGGLE_LONG_PRESS_EN
  logic long_o;
`endif

  int   errors = 0;
  int   checks = 0;
  logic exp_en = 1'b0;

  btn_toggle #(
    .DB_CYCLES   (4)
`ifdef BTN_TOGGLE_LONG_PRESS_EN
   ,.LONG_CYCLES (16)
`endif
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .btn_i   (btn_i),
    .en_o    (en_o),
    .press_o (press_o)
`ifdef BTN_TOGGLE_LONG_PRESS_EN
   ,.long_o  (long_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_ni = 1'b0;
    btn_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (en_o !== 1'b0 || press_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d en_o=%b press_o=%b expected 0/0", k, en_o, press_o);
      end
`ifdef BTN_TOGGLE_LONG_PRESS_EN
      checks++;
      if (long_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_long cyc=%0d long_o=%b expected 0", k, long_o);
      end
`endif
    end
    btn_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    exp_en = 1'b0;
  endtask

  task automatic test_toggle();
    for (int p = 0; p < 2; p++) begin
      btn_i = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (press_o !== 1'(k == 7)) begin
          errors++;
          $display("FAIL toggle_press p=%0d edge=%0d press_o=%b expected %b", p, k, press_o, k == 7);
        end
        checks++;
        if (en_o !== ((k >= 7) ? ~exp_en : exp_en)) begin
          errors++;
          $display("FAIL toggle_en p=%0d edge=%0d en_o=%b expected %b", p, k, en_o,
                   (k >= 7) ? ~exp_en : exp_en);
        end
      end
      exp_en = ~exp_en;
      btn_i  = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        checks++;
        if (press_o !== 1'b0 || en_o !== exp_en) begin
          errors++;
          $display("FAIL toggle_release p=%0d cyc=%0d press_o=%b en_o=%b expected 0/%b",
                   p, k, press_o, en_o, exp_en);
        end
      end
    end
  endtask

`ifdef BTN_TOGGLE_LONG_PRESS_EN
  task automatic test_long_press();
    btn_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (press_o !== 1'(k == 7) || long_o !== 1'(k == 22)) begin
        errors++;
        $display("FAIL long_pulses edge=%0d press_o=%b long_o=%b expected %b/%b",
                 k, press_o, long_o, k == 7, k == 22);
      end
      checks++;
      if (en_o !== 1'((k >= 7) && (k < 22))) begin
        errors++;
        $display("FAIL long_en edge=%0d en_o=%b expected %b", k, en_o, (k >= 7) && (k < 22));
      end
    end
    exp_en = 1'b0;
    btn_i  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (press_o !== 1'b0 || long_o !== 1'b0 || en_o !== exp_en) begin
        errors++;
        $display("FAIL long_release cyc=%0d press_o=%b long_o=%b en_o=%b expected 0/0/%b",
                 k, press_o, long_o, en_o, exp_en);
      end
    end
  endtask
`endif

  task automatic test_glitch();
    btn_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) btn_i = 1'b0;
      checks++;
      if (press_o !== 1'b0 || en_o !== exp_en) begin
        errors++;
        $display("FAIL glitch edge=%0d press_o=%b en_o=%b expected 0/%b", k, press_o, en_o, exp_en);
      end
    end
  endtask

  task automatic test_bounce();
    btn_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (press_o !== 1'(k == 7) || en_o !== ((k >= 7) ? ~exp_en : exp_en)) begin
        errors++;
        $display("FAIL bounce_press edge=%0d press_o=%b en_o=%b expected %b/%b",
                 k, press_o, en_o, k == 7, (k >= 7) ? ~exp_en : exp_en);
      end
    end
    exp_en = ~exp_en;
    btn_i  = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) btn_i = 1'b1;
      if (k == 8) btn_i = 1'b0;
      checks++;
      if (press_o !== 1'b0 || en_o !== exp_en) begin
        errors++;
        $display("FAIL bounce_hold edge=%0d press_o=%b en_o=%b expected 0/%b", k, press_o, en_o, exp_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_ni = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (press_o !== 1'b0 || en_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_outputs cyc=%0d press_o=%b en_o=%b expected 0/0", k, press_o, en_o);
      end
    end
    exp_en = 1'b0;
    rst_ni = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (press_o !== 1'(k == 7) || en_o !== 1'(k >= 7)) begin
        errors++;
        $display("FAIL midreset_press edge=%0d press_o=%b en_o=%b expected %b/%b",
                 k, press_o, en_o, k == 7, k >= 7);
      end
    end
    exp_en = 1'b1;
    btn_i  = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (en_o !== exp_en || press_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_final en_o=%b press_o=%b expected %b/0", en_o, press_o, exp_en);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    btn_i  = 1'b0;
    test_reset();
    test_toggle();
`ifdef BTN_TOGGLE_LONG_PRESS_EN
    test_long_press();
`endif
    test_glitch();
    test_bounce();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_btn_toggle
